// File: rtl/pipe_flow_pkg.sv
// pipe_flow_pkg: shared definitions for the pipe flow controller.
//   - state_e        : controller FSM states
//   - *_DEF          : default parameter values
//   - WD_LIMIT       : idle-cycle limit of the optional watchdog
//   - sat_inc16()    : 16-bit saturating increment used by the block counters
package pipe_flow_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned IN_DEPTH_DEF    = 1024;
  localparam int unsigned OUT_DEPTH_DEF   = 256;
  localparam int unsigned BLOCK_WORDS_DEF = 128;
  localparam int unsigned RST_CYCLES_DEF  = 17;
  localparam logic [19:0] WD_LIMIT        = 20'd1000000;

  // Block counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/block_counter.sv
// block_counter: counts accepted words and rolls every BLOCK_WORDS words
// into a saturating 16-bit block count.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr_i        : synchronous clear of word and block counts (wins over inc_i)
//   inc_i        : one accepted word this cycle
//   block_cnt_o  : completed blocks (registered)
module block_counter
  import pipe_flow_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int unsigned WORD_W      = $clog2(BLOCK_WORDS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] block_cnt_o
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [15:0]       blk_q, blk_d;

  // Next word/block count: the last word of a block bumps the block count.
  always_comb begin
    word_d = word_q;
    blk_d  = blk_q;
    if (clr_i) begin
      word_d = '0;
      blk_d  = 16'd0;
    end else if (inc_i) begin
      if (word_q == WORD_W'(BLOCK_WORDS - 1)) begin
        word_d = '0;
        blk_d  = sat_inc16(blk_q);
      end else begin
        word_d = word_q + WORD_W'(1);
      end
    end else begin
      word_d = word_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      blk_q  <= 16'd0;
    end else begin
      word_q <= word_d;
      blk_q  <= blk_d;
    end
  end

  assign block_cnt_o = blk_q;

endmodule

// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl: run-control FSM throttling host pipe traffic block by block.
// A run flushes both FIFOs, accepts num_blocks input blocks, waits until the
// same number of output blocks were read, then pulses done.
// Ports:
//   okClk, reset_n                 : clock, asynchronous active-low reset
//   start, stop, num_blocks        : run commands and run length
//   pipe_in_wr_count/_full/_strobe : input FIFO status and host writes
//   pipe_out_rd_count/_full/_strobe: output FIFO status and host reads
//   fifo_rst                       : FIFO/pattern reset, high during flush
//   pipe_in_ready/pipe_out_ready   : block-throttle flags
//   stream_en, busy, done          : streaming enable, run status, end pulse
//   blocks_in/blocks_out           : completed block counts
//   err_overflow, err_timeout      : sticky error flags
// Build option: define PIPE_FLOW_CTRL_WATCHDOG_EN to enable the inactivity
// watchdog driving err_timeout; otherwise err_timeout is constant 0.
module pipe_flow_ctrl
  import pipe_flow_pkg::*;
#(
  parameter int unsigned IN_DEPTH    = IN_DEPTH_DEF,
  parameter int unsigned OUT_DEPTH   = OUT_DEPTH_DEF,
  parameter int unsigned BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int unsigned RST_CYCLES  = RST_CYCLES_DEF
) (
  input  logic        okClk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] num_blocks,
  input  logic [9:0]  pipe_in_wr_count,
  input  logic [9:0]  pipe_out_rd_count,
  input  logic        pipe_in_full,
  input  logic        pipe_out_full,
  input  logic        pipe_in_strobe,
  input  logic        pipe_out_strobe,
  output logic        fifo_rst,
  output logic        pipe_in_ready,
  output logic        pipe_out_ready,
  output logic        stream_en,
  output logic        busy,
  output logic        done,
  output logic [15:0] blocks_in,
  output logic [15:0] blocks_out,
  output logic        err_overflow,
  output logic        err_timeout
);

  localparam int unsigned IN_THRESH  = IN_DEPTH - BLOCK_WORDS;
  // An output block can never be larger than the output FIFO itself.
  localparam int unsigned OUT_THRESH = (BLOCK_WORDS < OUT_DEPTH) ? BLOCK_WORDS : OUT_DEPTH;
  localparam int unsigned FLUSH_W    = $clog2(RST_CYCLES + 1);

  state_e             state_q, state_d;
  logic [15:0]        num_q, num_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic [15:0]        blocks_in_s, blocks_out_s;

  logic fifo_rst_q, fifo_rst_d, in_rdy_q, in_rdy_d, out_rdy_q, out_rdy_d;
  logic stream_q, stream_d, busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic start_acc_s, stop_s, act_q_s, act_d_s, in_acc_s, out_acc_s, ovf_s, wd_hit_s;

  assign start_acc_s = (state_q == ST_IDLE) && start;
  assign stop_s      = (state_q != ST_IDLE) && stop;
  assign act_q_s     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign act_d_s     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
  // A word counts only when legal; stop suppresses counting in its cycle.
  assign in_acc_s    = pipe_in_strobe && !pipe_in_full && (state_q == ST_RUN)
                       && (blocks_in_s < num_q) && !stop;
  assign out_acc_s   = pipe_out_strobe && (pipe_out_rd_count != 10'd0) && act_q_s
                       && (blocks_out_s < num_q) && !stop;
  assign ovf_s       = act_q_s && ((pipe_in_strobe && pipe_in_full)
                       || (pipe_out_strobe && (pipe_out_rd_count == 10'd0)));

  block_counter #(.BLOCK_WORDS(BLOCK_WORDS)) u_cnt_in (
    .clk(okClk), .rst_n(reset_n), .clr_i(start_acc_s), .inc_i(in_acc_s),
    .block_cnt_o(blocks_in_s)
  );

  block_counter #(.BLOCK_WORDS(BLOCK_WORDS)) u_cnt_out (
    .clk(okClk), .rst_n(reset_n), .clr_i(start_acc_s), .inc_i(out_acc_s),
    .block_cnt_o(blocks_out_s)
  );

  // State, run-length latch and flush timer registers.
  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      num_q   <= 16'd0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      flush_q <= flush_d;
    end
  end

  // Next-state logic; stop overrides every other transition.
  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    num_d   = start_acc_s ? num_blocks : num_q;
    if (stop_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_FLUSH;
            flush_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (flush_q == FLUSH_W'(RST_CYCLES - 1)) begin
            state_d = (num_q == 16'd0) ? ST_DONE : ST_RUN;
          end else begin
            flush_d = flush_q + FLUSH_W'(1);
          end
        end
        ST_RUN: begin
          if (wd_hit_s) begin
            state_d = ST_DONE;
          end else if (blocks_in_s == num_q) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (wd_hit_s || (blocks_out_s == num_q)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output next values; readys need the state both now and next so they drop
  // in the same cycle the FSM leaves RUN/DRAIN.
  always_comb begin
    fifo_rst_d = (state_d == ST_FLUSH);
    in_rdy_d   = (state_q == ST_RUN) && (state_d == ST_RUN)
                 && (32'(pipe_in_wr_count) <= IN_THRESH) && (blocks_in_s < num_q);
    out_rdy_d  = act_q_s && act_d_s && (32'(pipe_out_rd_count) >= OUT_THRESH);
    stream_d   = act_d_s && !pipe_out_full;
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    if (start_acc_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q || ovf_s;
    end
  end

  // Output registers.
  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_rst_q <= 1'b0;
      in_rdy_q   <= 1'b0;
      out_rdy_q  <= 1'b0;
      stream_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      fifo_rst_q <= fifo_rst_d;
      in_rdy_q   <= in_rdy_d;
      out_rdy_q  <= out_rdy_d;
      stream_q   <= stream_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef PIPE_FLOW_CTRL_WATCHDOG_EN
  logic [19:0] wd_q, wd_d;
  logic        err_to_q, err_to_d;

  assign wd_hit_s = act_q_s && (wd_q == WD_LIMIT);

  // Watchdog: counts quiet cycles while streaming, any host strobe restarts it.
  always_comb begin
    if (!act_q_s || pipe_in_strobe || pipe_out_strobe) begin
      wd_d = 20'd0;
    end else if (wd_q != WD_LIMIT) begin
      wd_d = wd_q + 20'd1;
    end else begin
      wd_d = wd_q;
    end
    if (start_acc_s) begin
      err_to_d = 1'b0;
    end else begin
      err_to_d = err_to_q || wd_hit_s;
    end
  end

  // Watchdog registers.
  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q     <= 20'd0;
      err_to_q <= 1'b0;
    end else begin
      wd_q     <= wd_d;
      err_to_q <= err_to_d;
    end
  end

  assign err_timeout = err_to_q;
`else
  assign wd_hit_s    = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign fifo_rst       = fifo_rst_q;
  assign pipe_in_ready  = in_rdy_q;
  assign pipe_out_ready = out_rdy_q;
  assign stream_en      = stream_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_overflow   = ovf_q;
  assign blocks_in      = blocks_in_s;
  assign blocks_out     = blocks_out_s;

endmodule

// File: doc/pipe_flow_ctrl.md
PIPE_FLOW_CTRL -- requirements
Module: pipe_flow_ctrl

Interface
REQ-001 Parameters (name, default, meaning): IN_DEPTH, 1024, input FIFO depth in 32-bit words.
REQ-002 OUT_DEPTH, 256, output FIFO read-side depth in 32-bit words.
REQ-003 BLOCK_WORDS, 128, words per host pipe block.
REQ-004 RST_CYCLES, 17, FIFO reset-plus-settle cycles (340 ns at 20 ns okClk).
REQ-005 Ports (name, direction, width, meaning): okClk, in, 1, sole clock. Reset is asynchronous and active-low.
REQ-006 reset_n, in, 1, asynchronous active-low reset.
REQ-007 start / stop, in, 1 each, single-cycle run commands.
REQ-008 num_blocks, in, 16, blocks per run; sampled on accepted start.
REQ-009 pipe_in_wr_count, in, 10, input FIFO write count.
REQ-010 pipe_out_rd_count, in, 10, output FIFO read count.
REQ-011 pipe_in_full / pipe_out_full, in, 1 each, FIFO full flags.
REQ-012 pipe_in_strobe / pipe_out_strobe, in, 1 each, host word write to input FIFO / word read from output FIFO.
REQ-013 fifo_rst, out, 1, active-high reset to both FIFOs and the pattern block.
REQ-014 pipe_in_ready / pipe_out_ready, out, 1 each, block-throttle flags to host.
REQ-015 stream_en, out, 1, enables pattern streaming between FIFOs.
REQ-016 busy, done, out, 1 each; done is a one-cycle pulse.
REQ-017 blocks_in / blocks_out, out, 16 each, completed-block counters.
REQ-018 err_overflow, out, 1, sticky strobe-while-full error.

Function
REQ-019 FSM states: IDLE, FLUSH, RUN, DRAIN, DONE; one state-register update per okClk.
REQ-020 IDLE + start: latch num_blocks, clear counters and err_overflow, enter FLUSH; start outside IDLE is ignored.
REQ-021 FLUSH: fifo_rst high for exactly RST_CYCLES cycles, then RUN (num_blocks = 0: DONE instead).
REQ-022 RUN: pipe_in_ready registered = (pipe_in_wr_count <= IN_DEPTH-BLOCK_WORDS) and (blocks_in < latched num_blocks); one-cycle latency from counts.
REQ-023 RUN/DRAIN: pipe_out_ready registered = (pipe_out_rd_count >= BLOCK_WORDS); low in all other states.
REQ-024 stream_en = (state RUN or DRAIN) and not pipe_out_full, registered.
REQ-025 Word counters (width log2(BLOCK_WORDS)) count strobes; wrap at BLOCK_WORDS-1 increments the matching block counter same cycle.
REQ-026 blocks_in == num_blocks in RUN: enter DRAIN; further pipe_in_strobe ignored by counter.
REQ-027 DRAIN: blocks_out == num_blocks enters DONE; DONE pulses done for one cycle, then IDLE.
REQ-028 Block counters saturate at 16'hFFFF; no wrap.
REQ-029 pipe_in_strobe with pipe_in_full, or pipe_out_strobe with pipe_out_rd_count == 0: set err_overflow; word not counted.
REQ-030 stop in any non-IDLE state: IDLE next cycle, all ready/stream outputs low; stop wins over same-cycle start and block completion.
REQ-031 busy = state not IDLE.

Reset
REQ-032 reset_n low: state IDLE, all outputs and counters 0, fifo_rst 0, immediately and asynchronously.
REQ-033 Reset deassertion mid-run does not resume the run; a new start is required.

Configuration
REQ-034 PIPE_FLOW_CTRL_WATCHDOG_EN defined: 20-bit counter clears on any strobe, counts in RUN/DRAIN; reaching 1,000,000 sets sticky err_timeout (added 1-bit output) and enters DONE.
REQ-035 Macro undefined: no counter, err_timeout tied 0, port retained.

Structure
REQ-036 Package pipe_flow_pkg holds the state enum and the default constants.
REQ-037 Sub-module block_counter (word/block counter with saturation), instantiated twice.

Verification
REQ-038 start, num_blocks=2 -> fifo_rst high 17 cycles, then RUN, pipe_in_ready=1 one cycle later.
REQ-039 pipe_in_wr_count 896 -> pipe_in_ready 1; 897 -> 0 one cycle later.
REQ-040 256 in-strobes, then pipe_out_rd_count 128 with 256 out-strobes -> blocks_in=2, DRAIN, blocks_out=2, done pulse, IDLE.
REQ-041 pipe_in_strobe with pipe_in_full=1 -> err_overflow=1, blocks_in unchanged; cleared by next start.
REQ-042 stop and start same cycle in RUN -> IDLE, busy 0; reset_n low mid-DRAIN -> all outputs 0 asynchronously.
